// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and sizing helpers for the mult/div sequencer.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    // Iteration counter width for a given operand width (at least one bit).
    function automatic int unsigned md_cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned MD_CNT_W = md_cnt_width(MD_WIDTH);

    // Even op codes (mult/div) treat operands as two's complement.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the datapath control and the mult/div sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix.
module muldiv_signfix #(
    parameter int unsigned N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        dout = neg ? ({N{1'b0}} - din) : din;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle radix-2 mult/multu/div/divu sequencer owning the HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic              Clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned    CNT_W    = md_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    // acc_hi: running product high half / partial remainder.
    // acc_lo: multiplier shifting out / dividend shifting out, quotient shifting in.
    // opnd:   multiplicand / divisor magnitude.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             op_div;
    logic             neg_main;
    logic             neg_rem;
    logic             dz_pend;

    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             start_signed;
    logic             start_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Operand classification at the request boundary.
    always_comb begin
        start_signed = md_is_signed(bus.op);
        start_div    = md_is_div(bus.op);
        a_neg        = start_signed & bus.a[WIDTH-1];
        b_neg        = start_signed & bus.b[WIDTH-1];
    end

    muldiv_signfix #(.N(WIDTH)) u_abs_a (
        .neg  (a_neg),
        .din  (bus.a),
        .dout (mag_a)
    );

    muldiv_signfix #(.N(WIDTH)) u_abs_b (
        .neg  (b_neg),
        .din  (bus.b),
        .dout (mag_b)
    );

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
    end

    muldiv_signfix #(.N(2*WIDTH)) u_fix_prod (
        .neg  (neg_main),
        .din  ({acc_hi, acc_lo}),
        .dout (prod_fixed)
    );

    muldiv_signfix #(.N(WIDTH)) u_fix_quot (
        .neg  (neg_main),
        .din  (acc_lo),
        .dout (quot_fixed)
    );

    muldiv_signfix #(.N(WIDTH)) u_fix_rem (
        .neg  (neg_rem),
        .din  (acc_hi),
        .dout (rem_fixed)
    );

    // Sequencer FSM, iteration datapath and HI/LO ownership.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz_pend  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= CNT_LAST;
                        dz_r   <= 1'b0;
                        busy_r <= 1'b1;
                        op_div <= start_div;
                        if (start_div && (bus.b == '0)) begin
                            // Divide by zero: preload the final HI/LO values as an
                            // unsigned remainder/quotient so FIX writes them unchanged.
                            acc_hi   <= bus.a;
                            acc_lo   <= '1;
                            opnd     <= '0;
                            neg_main <= 1'b0;
                            neg_rem  <= 1'b0;
                            dz_pend  <= 1'b1;
                            state    <= FIX;
                        end else begin
                            acc_hi   <= '0;
                            neg_main <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            dz_pend  <= 1'b0;
                            if (start_div) begin
                                acc_lo <= mag_a;
                                opnd   <= mag_b;
                                state  <= DIV;
                            end else begin
                                acc_lo <= mag_b;
                                opnd   <= mag_a;
                                state  <= MUL;
                            end
                        end
                    end else begin
                        if (bus.hi_we) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DIV: begin
                    acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        hi_r <= rem_fixed;
                        lo_r <= quot_fixed;
                    end else begin
                        hi_r <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fixed[WIDTH-1:0];
                    end
                    dz_r   <= dz_pend;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs onto the bundle.
    always_comb begin
        bus.busy     = busy_r;
        bus.done     = done_r;
        bus.div_zero = dz_r;
        bus.hi       = hi_r;
        bus.lo       = lo_r;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb[$];

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally disturb it while busy, then compare the popped
    // expectation against HI/LO when done pulses.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int busy_exp, input int disturb,
                          input logic we_with_start);
        int   busy_n;
        bit   got;
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (we_with_start) begin
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = 32'h0000BEEF;
        end
        sb.push_back(exp_t'{hi: eh, lo: el, dz: edz});
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            if (i == 0) begin
                check({tag, " busy@E0"}, 64'(bus.busy), 64'd1);
                check({tag, " dz_clr@E0"}, 64'(bus.div_zero), 64'd0);
                check({tag, " hi_hold"}, 64'(bus.hi), 64'(m_hi));
                check({tag, " lo_hold"}, 64'(bus.lo), 64'(m_lo));
            end
            if (i == disturb) begin
                bus.start = 1'b1;
                bus.op    = MD_DIV;
                bus.b     = 32'h0;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'h0000DEAD;
            end
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_n++;
        end
        check({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            e = sb.pop_front();
            check({tag, " busy_cycles"}, 64'(busy_n), 64'(busy_exp));
            check({tag, " hi"}, 64'(bus.hi), 64'(e.hi));
            check({tag, " lo"}, 64'(bus.lo), 64'(e.lo));
            check({tag, " div_zero"}, 64'(bus.div_zero), 64'(e.dz));
            check({tag, " busy@done"}, 64'(bus.busy), 64'd0);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check({tag, " done_1cyc"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int done_cnt;
        tests = 0;
        fails = 0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst dz", 64'(bus.div_zero), 64'd0);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);

        // Multiply
        run_op("mult 7*-3", MD_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, -1, 1'b0);
        run_op("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, -1, 1'b0);
        run_op("mult -1*-1", MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 33, -1, 1'b0);

        // Divide
        run_op("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1, 1'b0);
        run_op("div 7/-2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 33, -1, 1'b0);
        run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, -1, 1'b0);
        run_op("div ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, -1, 1'b0);
        run_op("divu max/1", MD_DIVU, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0, 33, -1, 1'b0);
        run_op("divu 3/5", MD_DIVU, 32'd3, 32'd5, 32'd3, 32'd0, 1'b0, 33, -1, 1'b0);

        // Divide by zero, then the flag clears on the next accepted start
        run_op("div 5/0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, -1, 1'b0);
        run_op("divu big/0", MD_DIVU, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 1, -1, 1'b0);
        run_op("multu 2*3", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33, -1, 1'b0);

        // start/hi_we/lo_we while busy are ignored
        run_op("mult disturbed", MD_MULT, 32'h00012345, 32'h00000100, 32'h0, 32'h01234500, 1'b0, 33, 10, 1'b0);

        // IDLE register writes
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h00001234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'h1234);
        check("mthi lo_keep", 64'(bus.lo), 64'(m_lo));
        m_hi = 32'h00001234;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h00005555;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mthi+mtlo hi", 64'(bus.hi), 64'h5555);
        check("mthi+mtlo lo", 64'(bus.lo), 64'h5555);
        check("mt done", 64'(bus.done), 64'd0);
        m_hi = 32'h00005555;
        m_lo = 32'h00005555;

        // start beats simultaneous HI/LO writes
        run_op("divu 50/6 +we", MD_DIVU, 32'd50, 32'd6, 32'd2, 32'd8, 1'b0, 33, -1, 1'b1);

        // Reset mid-divide discards everything
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.a     = 32'd1000;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre-rst busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst hi", 64'(bus.hi), 64'd0);
        check("midrst lo", 64'(bus.lo), 64'd0);
        check("midrst dz", 64'(bus.div_zero), 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("midrst no_done", 64'(done_cnt), 64'd0);
        run_op("divu 9/4", MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 33, -1, 1'b0);

        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
